// File: rtl/hilo_if.sv
// HI/LO controller bus: EX-stage mul/div request, unit completion, writeback
// MTHI/MTLO writes and the HI/LO values and stall/error flags returned.
interface hilo_if;
  logic        md_start;
  logic [5:0]  funct;
  logic        md_done;
  logic [63:0] md_result;
  logic        flush;
  logic        wb_hi_we;
  logic        wb_lo_we;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_req;
  logic        md_timeout;

  modport master (
    output md_start, funct, md_done, md_result, flush,
           wb_hi_we, wb_lo_we, wb_hi, wb_lo,
    input  hi, lo, stall_req, md_timeout
  );

  modport slave (
    input  md_start, funct, md_done, md_result, flush,
           wb_hi_we, wb_lo_we, wb_hi, wb_lo,
    output hi, lo, stall_req, md_timeout
  );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences mul/div ops, stalls the pipeline and
// commits results. Define HILO_FWD_EN to forward same-cycle writes onto hi/lo.
//
// state  | meaning
// IDLE   | no operation pending, watching EX for a mul/div
// BUSY   | waiting on md_done, watchdog counting
// COMMIT | latched result being written to HI/LO
module hilo_ctrl (
  input  logic  clk,
  input  logic  rst,
  hilo_if.slave bus
);
  localparam logic [5:0] FUNCT_MULT   = 6'h18;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIV    = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1B;
  localparam logic [5:0] FUNCT2_MADD  = 6'h00;
  localparam logic [5:0] FUNCT2_MADDU = 6'h01;
  localparam logic [5:0] FUNCT2_MUL   = 6'h02;
  localparam logic [5:0] FUNCT2_MSUB  = 6'h04;
  localparam logic [5:0] FUNCT2_MSUBU = 6'h05;

  typedef enum logic [1:0] {IDLE, BUSY, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  rst_sync;
  logic        rst_s;
  logic [5:0]  wd_cnt, wd_nxt;
  logic [63:0] res_q;
  logic        wr_q;
  logic [31:0] hi_q, lo_q;
  logic        timeout_q;
  logic        is_md, is_wr, start_ok;
  logic        stall, enter, latch, commit_we, set_to;

  // assert immediately, release aligned to clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_s = rst_sync[1];

  always_comb begin
    is_md = 1'b0;
    is_wr = 1'b0;
    case (bus.funct)
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
      FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB, FUNCT2_MSUBU: begin
        is_md = 1'b1;
        is_wr = 1'b1;
      end
      FUNCT2_MUL: is_md = 1'b1;
      default: ;
    endcase
  end

  assign start_ok = bus.md_start && !bus.flush && is_md;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    enter     = 1'b0;
    latch     = 1'b0;
    commit_we = 1'b0;
    set_to    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          stall     = 1'b1;
          enter     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (bus.md_done) begin
          latch     = 1'b1;
          state_nxt = COMMIT;
        end else if (wd_cnt == 6'd62) begin
          set_to    = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
`ifndef HILO_FWD_EN
        stall = 1'b1;
`endif
        commit_we = wr_q && !bus.flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // counter ends at 63 on the edge that leaves BUSY after 63 cycles
  always_comb begin
    wd_nxt = wd_cnt;
    if (enter)              wd_nxt = 6'd0;
    else if (state == BUSY) wd_nxt = wd_cnt + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      state     <= IDLE;
      wd_cnt    <= 6'd0;
      res_q     <= 64'd0;
      wr_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_nxt;
      if (enter)  wr_q      <= is_wr;
      if (latch)  res_q     <= bus.md_result;
      if (set_to) timeout_q <= 1'b1;
      if (commit_we) begin
        hi_q <= res_q[63:32];
        lo_q <= res_q[31:0];
      end else begin
        if (bus.wb_hi_we) hi_q <= bus.wb_hi;
        if (bus.wb_lo_we) lo_q <= bus.wb_lo;
      end
    end
  end

  assign bus.stall_req  = stall && rst_s;
  assign bus.md_timeout = timeout_q;

`ifdef HILO_FWD_EN
  assign bus.hi = commit_we ? res_q[63:32] :
                  (bus.wb_hi_we && rst_s) ? bus.wb_hi : hi_q;
  assign bus.lo = commit_we ? res_q[31:0] :
                  (bus.wb_lo_we && rst_s) ? bus.wb_lo : lo_q;
`else
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
`endif
endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: per-cycle comparison against an
// operation-level model plus directed literal checks.
module tb_hilo_ctrl;
  localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B, F_MADD  = 6'h00, F_MADDU = 6'h01;
  localparam logic [5:0] F_MUL   = 6'h02, F_MSUB  = 6'h04, F_MSUBU = 6'h05;
`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   stall_cnt = 0;
  int   snap;

  hilo_if bus ();
  hilo_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writes_hilo(input logic [5:0] f);
    logic [5:0] set [8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MADD, F_MADDU, F_MSUB, F_MSUBU};
    foreach (set[i]) if (set[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_md(input logic [5:0] f);
    return writes_hilo(f) || (f == F_MUL);
  endfunction

  // model: an op is either running (age = cycles spent) or finishing this cycle
  logic [1:0]  rs;
  logic [31:0] m_hi, m_lo;
  logic        run, fin, fin_wr, m_to;
  logic [63:0] fin_res;
  int          age;
  logic        start_ok;

  assign start_ok = bus.md_start && !bus.flush && is_md(bus.funct);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs <= 2'b00; m_hi <= 0; m_lo <= 0; run <= 0; fin <= 0;
      fin_wr <= 0; fin_res <= 0; m_to <= 0; age <= 0;
    end else begin
      rs <= {rs[0], 1'b1};
      if (rs[1]) begin
        if (fin && !bus.flush && fin_wr) begin
          m_hi <= fin_res[63:32];
          m_lo <= fin_res[31:0];
        end else begin
          if (bus.wb_hi_we) m_hi <= bus.wb_hi;
          if (bus.wb_lo_we) m_lo <= bus.wb_lo;
        end
        fin <= 1'b0;
        if (run) begin
          age <= age + 1;
          if (bus.flush) run <= 1'b0;
          else if (bus.md_done) begin
            run <= 1'b0; fin <= 1'b1; fin_res <= bus.md_result;
          end else if (age + 1 == 63) begin
            run <= 1'b0; m_to <= 1'b1;
          end
        end else if (!fin && start_ok) begin
          run <= 1'b1; age <= 0; fin_wr <= writes_hilo(bus.funct);
        end
      end
    end
  end

  logic [31:0] e_hi, e_lo;
  logic        e_stall;
  always @(negedge clk) begin
    if (!rs[1]) begin
      e_hi = 0; e_lo = 0; e_stall = 0;
    end else begin
      e_stall = run || (!fin && start_ok) || (!FWD && fin);
      if (FWD && fin && !bus.flush && fin_wr) begin
        e_hi = fin_res[63:32]; e_lo = fin_res[31:0];
      end else begin
        e_hi = (FWD && bus.wb_hi_we) ? bus.wb_hi : m_hi;
        e_lo = (FWD && bus.wb_lo_we) ? bus.wb_lo : m_lo;
      end
    end
    chk("cyc_hi", bus.hi, e_hi);
    chk("cyc_lo", bus.lo, e_lo);
    chk("cyc_stall", bus.stall_req, e_stall);
    chk("cyc_timeout", bus.md_timeout, m_to);
    if (bus.stall_req) stall_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [5:0] f);
    bus.md_start = 1'b1;
    bus.funct    = f;
    tick();
    bus.md_start = 1'b0;
  endtask

  initial begin
    bus.md_start = 0; bus.funct = 6'h3F; bus.md_done = 0; bus.md_result = 0;
    bus.flush = 0; bus.wb_hi_we = 0; bus.wb_lo_we = 0; bus.wb_hi = 0; bus.wb_lo = 0;
    repeat (3) tick();
    chk("reset_hi", bus.hi, 0);
    chk("reset_stall", bus.stall_req, 0);
    rst = 1'b1;
    repeat (3) tick();

    // MULT, done three cycles after entry
    snap = stall_cnt;
    start_op(F_MULT);
    tick(); tick();
    bus.md_done = 1; bus.md_result = 64'h00000001_FFFFFFFE;
    tick();
    bus.md_done = 0;
    tick(); tick();
    chk("mult_stall_cycles", stall_cnt - snap, FWD ? 4 : 5);
    chk("mult_hi", bus.hi, 32'h1);
    chk("mult_lo", bus.lo, 32'hFFFFFFFE);

    // MUL stalls but never writes HI/LO
    start_op(F_MUL);
    bus.md_done = 1; bus.md_result = 64'hDEADBEEF_CAFEF00D;
    tick();
    bus.md_done = 0;
    tick(); tick();
    chk("mul_hi_kept", bus.hi, 32'h1);
    chk("mul_lo_kept", bus.lo, 32'hFFFFFFFE);

    // DIV: flush beats a simultaneous done
    start_op(F_DIV);
    tick();
    bus.flush = 1; bus.md_done = 1; bus.md_result = 64'h5555_5555_5555_5555;
    tick();
    bus.flush = 0; bus.md_done = 0;
    chk("flush_stall", bus.stall_req, 0);
    tick();
    chk("flush_hi_kept", bus.hi, 32'h1);

    // done in the entry cycle is ignored
    bus.md_start = 1; bus.funct = F_MULTU; bus.md_done = 1;
    bus.md_result = 64'h11111111_22222222;
    tick();
    bus.md_start = 0; bus.md_done = 0;
    tick();
    chk("entry_done_ignored", bus.stall_req, 1);
    bus.md_done = 1; bus.md_result = 64'h33333333_44444444;
    tick();
    bus.md_done = 0;
    tick();
    chk("late_done_hi", bus.hi, 32'h33333333);
    chk("late_done_lo", bus.lo, 32'h44444444);

    // COMMIT beats a same-cycle MTHI
    start_op(F_MADD);
    bus.md_done = 1; bus.md_result = {32'hA, 32'h7};
    tick();
    bus.md_done = 0; bus.wb_hi_we = 1; bus.wb_hi = 32'hB;
    tick();
    bus.wb_hi_we = 0;
    chk("commit_wins_hi", bus.hi, 32'hA);
    chk("commit_wins_lo", bus.lo, 32'h7);

    // plain MTHI/MTLO
    bus.wb_hi_we = 1; bus.wb_hi = 32'h1234; bus.wb_lo_we = 1; bus.wb_lo = 32'h5678;
    tick();
    bus.wb_hi_we = 0; bus.wb_lo_we = 0;
    chk("mthi", bus.hi, 32'h1234);
    chk("mtlo", bus.lo, 32'h5678);

    // flush during COMMIT drops the write
    start_op(F_MSUBU);
    bus.md_done = 1; bus.md_result = 64'hFFFF0000_0000FFFF;
    tick();
    bus.md_done = 0; bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("commit_flush_hi", bus.hi, 32'h1234);
    chk("commit_flush_lo", bus.lo, 32'h5678);

    // non-md funct and flushed start do not stall
    bus.md_start = 1; bus.funct = 6'h20;
    #1 chk("non_md_stall", bus.stall_req, 0);
    tick();
    bus.funct = F_MULT; bus.flush = 1;
    #1 chk("flushed_start_stall", bus.stall_req, 0);
    tick();
    bus.md_start = 0; bus.flush = 0;

    // watchdog: DIVU never completes
    start_op(F_DIVU);
    repeat (62) tick();
    chk("wd_still_busy", bus.stall_req, 1);
    chk("wd_not_yet", bus.md_timeout, 0);
    tick();
    chk("wd_timeout", bus.md_timeout, 1);
    chk("wd_idle", bus.stall_req, 0);

    // timeout is sticky across a normal op
    start_op(F_MULTU);
    bus.md_done = 1; bus.md_result = 64'h0000ABCD_00001234;
    tick();
    bus.md_done = 0;
    tick(); tick();
    chk("sticky_timeout", bus.md_timeout, 1);
    chk("after_to_hi", bus.hi, 32'h0000ABCD);

    // reset mid-BUSY
    start_op(F_MULT);
    tick();
    rst = 0;
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_stall", bus.stall_req, 0);
    chk("rst_timeout", bus.md_timeout, 0);
    bus.md_done = 1; bus.md_result = 64'hFFFFFFFF_FFFFFFFF;
    tick(); tick();
    bus.md_done = 0;
    rst = 1;
    repeat (4) tick();
    chk("post_rst_hi", bus.hi, 0);
    chk("post_rst_lo", bus.lo, 0);
    chk("post_rst_stall", bus.stall_req, 0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 md_start  input  1  EX holds a valid multiply/divide instruction this cycle.
REQ-005 funct  input  FUNCT_BUS  function code of the EX instruction (funct.v encodings).
REQ-006 md_done  input  1  completion from the multiply/divide unit.
REQ-007 md_result  input  DOUBLE_DATA_BUS  64-bit result from the multiply/divide unit: [63:32] to HI, [31:0] to LO.
REQ-008 flush  input  1  pipeline flush; kills the pending operation.
REQ-009 wb_hi_we, wb_lo_we  input  1 each  MTHI/MTLO write enables from writeback.
REQ-010 wb_hi, wb_lo  input  DATA_BUS each  MTHI/MTLO write data.
REQ-011 hi, lo  output  DATA_BUS each  current HI/LO, fed back to the multiply/divide unit and to MFHI/MFLO.
REQ-012 stall_req  output  1  request to freeze IF/ID/EX.
REQ-013 md_timeout  output  1  sticky watchdog error flag.

Function
REQ-014 The block SHALL classify FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB and FUNCT2_MSUBU as HI/LO writers, and FUNCT2_MUL as a non-writer that still stalls.
REQ-015 The FSM SHALL have the states IDLE, BUSY and COMMIT.
REQ-016 In IDLE, when md_start=1, flush=0 and funct is in the REQ-014 set, the FSM SHALL go to BUSY; otherwise it SHALL stay in IDLE.
REQ-017 stall_req SHALL be combinational: it is 1 in IDLE when the REQ-016 entry condition is true, and 1 throughout BUSY.
REQ-018 md_done SHALL be ignored in the cycle the FSM enters BUSY, and SHALL be sampled only from the first BUSY cycle onward.
REQ-019 In BUSY, on md_done=1, the block SHALL latch md_result and the writer flag, and go to COMMIT.
REQ-020 In COMMIT, stall_req SHALL be 0, HI/LO SHALL be written from the latched result if the writer flag is set, and the FSM SHALL return to IDLE.
REQ-021 A flush in BUSY or COMMIT SHALL return the FSM to IDLE with no HI/LO write; the flush SHALL take priority over md_done.
REQ-022 For MTHI/MTLO, wb_hi_we and wb_lo_we SHALL each write their register at the clock edge.
REQ-023 If a writeback write and a COMMIT write hit the same register in the same cycle, the COMMIT write SHALL win.
REQ-024 Watchdog: a 6-bit counter SHALL clear on BUSY entry and increment each cycle spent in BUSY.
REQ-025 When the watchdog counter reaches 63, md_timeout SHALL set and the FSM SHALL go to IDLE without a write.
REQ-026 md_timeout SHALL clear only on reset.
REQ-027 Latency SHALL be: stall released on the cycle after md_done is seen; HI/LO visible on the cycle after COMMIT.

Reset
REQ-028 Reset SHALL be asynchronous on assertion (rst=0) and synchronous on release.
REQ-029 On reset: FSM=IDLE, hi=0, lo=0, stall_req=0 (since not in BUSY and md_start is masked), md_timeout=0, watchdog=0.
REQ-030 A reset mid-operation SHALL abandon the operation with no HI/LO write.

Configuration
REQ-031 Macro HILO_FWD_EN SHALL control forwarding of writeback writes onto the outputs.
REQ-032 With HILO_FWD_EN defined, hi/lo SHALL combinationally forward a same-cycle COMMIT write, else a same-cycle wb write, else the register value.
REQ-033 Without HILO_FWD_EN, hi/lo SHALL be the register value only, and stall_req SHALL additionally be 1 in COMMIT, so consumers read after the update.

Verification
REQ-034 MULT entry with md_done 3 cycles later, md_result=64'h00000001_FFFFFFFE -> stall_req high 4 cycles, then hi=32'h1, lo=32'hFFFFFFFE.
REQ-035 FUNCT2_MUL with md_done -> stall then release, with hi/lo unchanged.
REQ-036 DIV in BUSY, with flush and md_done asserted together -> IDLE, no write, stall_req=0 next cycle.
REQ-037 COMMIT writing HI=32'hA while wb_hi_we=1 with wb_hi=32'hB -> hi=32'hA.
REQ-038 DIVU with md_done never asserted -> md_timeout=1 after 63 BUSY cycles, FSM in IDLE.
REQ-039 rst=0 asserted mid-BUSY -> all outputs 0 immediately, no write after release.
